// File: rtl/neuro_fixed_pkg.sv
// Shared Q4.14 fixed-point definitions for the cortical column datapath.
// Holds the sample format, unit constants and the common saturator.
package neuro_fixed_pkg;

    localparam int WIDTH = 18;
    localparam int FRAC  = 14;
    localparam int ONE   = 16384;
    localparam int TWO   = 32768;
    localparam int SUMW  = WIDTH + 2;

    function automatic logic signed [WIDTH-1:0] sat_q14(
        input logic signed [SUMW-1:0] v,
        input int                     clamp
    );
        logic signed [SUMW-1:0] hi;
        logic signed [SUMW-1:0] lo;
        hi = SUMW'(clamp);
        lo = -hi;
        if (v > hi)
            sat_q14 = hi[WIDTH-1:0];
        else if (v < lo)
            sat_q14 = lo[WIDTH-1:0];
        else
            sat_q14 = v[WIDTH-1:0];
    endfunction

endpackage

// File: rtl/l1_feedback_source_if.sv
// Sample bundle between the column sources and the L1 feedback filter.
// master drives raw samples and strobes, slave returns filtered outputs.
interface l1_feedback_source_if;
    import neuro_fixed_pkg::*;

    logic                    clk_en;
    logic                    hold;
    logic signed [WIDTH-1:0] adjacent_l5_in;
    logic signed [WIDTH-1:0] distant_l5_in;
    logic signed [WIDTH-1:0] matrix_drive_in;
    logic signed [WIDTH-1:0] feedback_input_1;
    logic signed [WIDTH-1:0] feedback_input_2;
    logic signed [WIDTH-1:0] matrix_thalamic_input;
    logic                    settled;

    modport master (
        output clk_en, hold,
        output adjacent_l5_in, distant_l5_in, matrix_drive_in,
        input  feedback_input_1, feedback_input_2,
        input  matrix_thalamic_input, settled
    );

    modport slave (
        input  clk_en, hold,
        input  adjacent_l5_in, distant_l5_in, matrix_drive_in,
        output feedback_input_1, feedback_input_2,
        output matrix_thalamic_input, settled
    );

endinterface

// File: rtl/ema_sat_q14.sv
// Shift-based exponential moving average with output saturation.
// The shift floors toward -inf, so tiny negative steps still move y.
module ema_sat_q14
    import neuro_fixed_pkg::*;
#(
    parameter int SHIFT = 2,
    parameter int CLAMP = TWO
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] x,
    output logic signed [WIDTH-1:0] y
);

    logic signed [WIDTH:0]   diff;
    logic signed [WIDTH:0]   step;
    logic signed [SUMW-1:0]  sum;

    always_comb begin
        diff = {x[WIDTH-1], x} - {y[WIDTH-1], y};
        step = diff >>> SHIFT;
        sum  = {{2{y[WIDTH-1]}}, y} + {step[WIDTH], step};
    end

    always_ff @(posedge clk) begin
        if (rst)
            y <= '0;
        else if (en)
            y <= sat_q14(sum, CLAMP);
    end

endmodule

// File: rtl/l1_feedback_source.sv
// Layer 1 apical-modulation source: three filtered feedback paths,
// a conduction delay on the distant path and a settle indicator.
module l1_feedback_source
    import neuro_fixed_pkg::*;
#(
    parameter int FB1_SHIFT    = 2,
    parameter int FB2_SHIFT    = 3,
    parameter int MATRIX_SHIFT = 4,
    parameter int FB2_DELAY    = 4,
    parameter int SETTLE_TICKS = 64,
    parameter int CLAMP        = TWO
) (
    input  logic                  clk,
    input  logic                  rst,
    l1_feedback_source_if.slave   io
);

    localparam int CW = $clog2(SETTLE_TICKS + 1);

    logic                    upd;
    logic signed [WIDTH-1:0] dline [FB2_DELAY];
    logic [CW-1:0]           cnt;

    // The delay line follows clk_en alone; hold only freezes filters.
    assign upd = io.clk_en & ~io.hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FB2_DELAY; i++)
                dline[i] <= '0;
        end else if (io.clk_en) begin
            dline[0] <= io.distant_l5_in;
            for (int i = 1; i < FB2_DELAY; i++)
                dline[i] <= dline[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (upd && cnt != CW'(SETTLE_TICKS))
            cnt <= cnt + 1'b1;
    end

    assign io.settled = (cnt == CW'(SETTLE_TICKS));

    ema_sat_q14 #(
        .SHIFT (FB1_SHIFT),
        .CLAMP (CLAMP)
    ) u_fb1 (
        .clk (clk),
        .rst (rst),
        .en  (upd),
        .x   (io.adjacent_l5_in),
        .y   (io.feedback_input_1)
    );

    ema_sat_q14 #(
        .SHIFT (FB2_SHIFT),
        .CLAMP (CLAMP)
    ) u_fb2 (
        .clk (clk),
        .rst (rst),
        .en  (upd),
        .x   (dline[FB2_DELAY-1]),
        .y   (io.feedback_input_2)
    );

    ema_sat_q14 #(
        .SHIFT (MATRIX_SHIFT),
        .CLAMP (CLAMP)
    ) u_mtx (
        .clk (clk),
        .rst (rst),
        .en  (upd),
        .x   (io.matrix_drive_in),
        .y   (io.matrix_thalamic_input)
    );

endmodule

// File: tb/tb_l1_feedback_source.sv
// Self-checking bench for l1_feedback_source against an arithmetic model.
// Directed test-plan steps followed by a randomized stretch.
module tb_l1_feedback_source;

    logic clk;
    logic rst;
    int   nvec;
    int   nerr;

    l1_feedback_source_if io ();

    l1_feedback_source dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    int m_fb1;
    int m_fb2;
    int m_mtx;
    int m_cnt;
    int dq[$];

    function automatic int ema_ref(int y, int x, int s);
        int d;
        int p;
        int st;
        int r;
        d = x - y;
        p = 1 << s;
        if (d >= 0)
            st = d / p;
        else
            st = -((-d + p - 1) / p);
        r = y + st;
        if (r > 32768)
            r = 32768;
        if (r < -32768)
            r = -32768;
        return r;
    endfunction

    task automatic check(input string tag,
                         input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_fb1 = 0;
        m_fb2 = 0;
        m_mtx = 0;
        m_cnt = 0;
        dq.delete();
        for (int i = 0; i < 4; i++)
            dq.push_back(0);
    endtask

    task automatic cyc(input bit r, input bit en, input bit h,
                       input int a, input int d, input int m);
        int oldest;
        @(negedge clk);
        rst                = r;
        io.clk_en          = en;
        io.hold            = h;
        io.adjacent_l5_in  = 18'(a);
        io.distant_l5_in   = 18'(d);
        io.matrix_drive_in = 18'(m);
        @(posedge clk);
        if (r) begin
            model_reset();
        end else if (en) begin
            oldest = dq[$];
            if (!h) begin
                m_fb1 = ema_ref(m_fb1, a, 2);
                m_fb2 = ema_ref(m_fb2, oldest, 3);
                m_mtx = ema_ref(m_mtx, m, 4);
                if (m_cnt < 64)
                    m_cnt++;
            end
            dq.push_front(d);
            void'(dq.pop_back());
        end
        #1;
        check("fb1", io.feedback_input_1, m_fb1);
        check("fb2", io.feedback_input_2, m_fb2);
        check("mtx", io.matrix_thalamic_input, m_mtx);
        check("settled", {31'd0, io.settled}, (m_cnt == 64) ? 1 : 0);
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, 0, 0, 0);
    endtask

    function automatic int rnd18();
        logic signed [17:0] v;
        v = 18'($urandom);
        return int'(v);
    endfunction

    initial begin
        nvec = 0;
        nerr = 0;
        rst = 1'b1;
        io.clk_en = 1'b0;
        io.hold = 1'b0;
        io.adjacent_l5_in = '0;
        io.distant_l5_in = '0;
        io.matrix_drive_in = '0;
        model_reset();

        // reset state
        do_reset();
        do_reset();
        check("rst_fb1", io.feedback_input_1, 0);
        check("rst_settled", {31'd0, io.settled}, 0);

        // step response
        cyc(0, 1, 0, 16384, 0, 0);
        check("step_t1", io.feedback_input_1, 4096);
        cyc(0, 1, 0, 16384, 0, 0);
        check("step_t2", io.feedback_input_1, 7168);
        cyc(0, 1, 0, 16384, 0, 0);
        check("step_t3", io.feedback_input_1, 9472);
        check("step_mtx", io.matrix_thalamic_input, 0);
        check("step_fb2", io.feedback_input_2, 0);

        // distant delay
        do_reset();
        for (int t = 1; t <= 6; t++) begin
            cyc(0, 1, 0, 0, 16384, 0);
            if (t == 4)
                check("dly_t4", io.feedback_input_2, 0);
            if (t == 5)
                check("dly_t5", io.feedback_input_2, 2048);
            if (t == 6)
                check("dly_t6", io.feedback_input_2, 3840);
        end

        // positive and negative saturation on all paths
        do_reset();
        cyc(0, 1, 0, 98304, 98304, 98304);
        check("satp_t1", io.feedback_input_1, 24576);
        for (int t = 0; t < 8; t++)
            cyc(0, 1, 0, 98304, 98304, 98304);
        check("satp_hold", io.feedback_input_1, 32768);
        do_reset();
        cyc(0, 1, 0, -98304, -98304, -98304);
        check("satn_t1", io.feedback_input_1, -24576);
        for (int t = 0; t < 8; t++)
            cyc(0, 1, 0, -98304, -98304, -98304);
        check("satn_hold", io.feedback_input_1, -32768);

        // 1-of-4 clk_en gating matches the step sequence
        do_reset();
        for (int t = 1; t <= 3; t++) begin
            for (int k = 0; k < 3; k++)
                cyc(0, 0, 0, 16384, 0, 0);
            cyc(0, 1, 0, 16384, 0, 0);
            if (t == 1)
                check("gate_t1", io.feedback_input_1, 4096);
            if (t == 2)
                check("gate_t2", io.feedback_input_1, 7168);
            if (t == 3)
                check("gate_t3", io.feedback_input_1, 9472);
        end

        // hold freezes filters, delay line still advances
        cyc(0, 1, 1, 0, 16384, 0);
        cyc(0, 1, 1, 0, 16384, 0);
        cyc(0, 1, 1, 0, 16384, 0);
        check("hold_fb1", io.feedback_input_1, 9472);
        cyc(0, 1, 0, 16384, 0, 0);
        cyc(0, 1, 0, 16384, 0, 0);
        check("hold_fb2", io.feedback_input_2, 2048);

        // settle timing, with idle cycles that must not count
        do_reset();
        for (int t = 1; t <= 63; t++) begin
            if (t % 8 == 0)
                cyc(0, 0, 0, rnd18(), rnd18(), rnd18());
            cyc(0, 1, 0, rnd18(), rnd18(), rnd18());
        end
        check("settle_63", {31'd0, io.settled}, 0);
        cyc(0, 1, 0, 0, 0, 0);
        check("settle_64", {31'd0, io.settled}, 1);

        // reset mid-step overrides clk_en and restarts counting
        do_reset();
        for (int t = 0; t < 30; t++)
            cyc(0, 1, 0, 16384, 16384, 16384);
        cyc(1, 1, 0, 16384, 16384, 16384);
        check("mrst_fb1", io.feedback_input_1, 0);
        check("mrst_fb2", io.feedback_input_2, 0);
        check("mrst_mtx", io.matrix_thalamic_input, 0);
        check("mrst_settled", {31'd0, io.settled}, 0);
        for (int t = 0; t < 64; t++)
            cyc(0, 1, 0, 16384, 16384, 16384);
        check("mrst_resettle", {31'd0, io.settled}, 1);

        // floor rounding of a tiny negative input
        do_reset();
        cyc(0, 1, 0, -1, -1, -1);
        check("neg_t1", io.feedback_input_1, -1);
        cyc(0, 1, 0, -1, -1, -1);
        cyc(0, 1, 0, -1, -1, -1);
        check("neg_stable", io.feedback_input_1, -1);

        // randomized stretch
        do_reset();
        for (int t = 0; t < 400; t++) begin
            cyc(($urandom_range(0, 99) == 0),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 9) == 0),
                rnd18(), rnd18(), rnd18());
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule
